goblin_ctrl: RTL and testbench
==============================

Name: goblin_ctrl

Overview:
- Enemy (goblin) movement controller; drives the Gobx/Goby lookup coordinates into the tile map.
- Consumes the map's four neighbour tile codes (up/down/left/right) plus the digger position.
- Steps the goblin one tile per move slot through empty tunnel only, chasing the digger.
- Raises a sticky caught flag on collision.

Parameters:
- START_X, 0, spawn row (0..9)
- START_Y, 14, spawn column (0..14)
- SPAWN_DELAY, 8, game ticks between reset release and first move (1..255)
- MOVE_DIV, 2, game ticks per goblin step (1..15)

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle game-step strobe
- enable  in  1  game running; 0 freezes all counters and position
- digx  in  4  digger row
- digy  in  4  digger column
- up  in  3  tile code at (gobx-1, goby); boundary code when gobx==0
- down  in  3  tile code at (gobx+1, goby); boundary when gobx==9
- left  in  3  tile code at (gobx, goby-1); boundary when goby==0
- right  in  3  tile code at (gobx, goby+1); boundary when goby==14
- gobx  out  4  goblin row, feeds map Gobx
- goby  out  4  goblin column, feeds map Goby
- dir  out  2  last move direction
- active  out  1  goblin is roaming
- caught  out  1  goblin reached the digger; sticky

Behaviour:
- Tile codes:
  - 0 = empty; the only passable code.
  - 3 = dirt, 4 = emerald, 5 = bag, 7 = boundary; all blocked.
- Neighbour inputs are combinational from the current gobx/goby. They are sampled in the tick cycle; the new position is registered at that edge, so latency is 1 clock.
- Reset values: gobx=START_X, goby=START_Y, dir=LEFT, active=0, caught=0, all counters=0, state=WAIT. Reset applies mid-move and in any state.
- State machine, states WAIT, ROAM, CAUGHT:
  - WAIT: counts enable&tick. When the count reaches SPAWN_DELAY: go to ROAM, active=1, move counter=0.
  - ROAM: on enable&tick the move counter increments. When it reaches MOVE_DIV-1 with tick, the counter clears and one step is evaluated (a move slot).
  - CAUGHT: gobx/goby/dir frozen, active=0, caught=1. Exits only by rst.
- Catch check:
  - Every cycle in ROAM, with no tick needed.
  - If gobx==digx and goby==digy: next state CAUGHT and caught=1 on the following edge.
  - Catch has priority over a move slot in the same cycle; no step is taken.
- Direction selection in a move slot:
  - dx = digx-gobx and dy = digy-goby, 5-bit signed.
  - Primary axis is the one with larger |d|; on a tie the row axis is primary.
  - Candidate order:
    1. primary toward-digger
    2. secondary toward-digger (skipped if that delta is 0)
    3. current dir
    4. fixed order UP, LEFT, DOWN, RIGHT
  - Reverse of the current dir is excluded from all of the above.
  - The first passable candidate is taken.
  - If none is passable, take the reverse if passable; otherwise hold position and keep dir.
- Step update:
  - UP: gobx-1. DOWN: gobx+1. LEFT: goby-1. RIGHT: goby+1. dir is updated to the move taken.
  - No wrap-around: coordinates stay within 0..9 / 0..14 because edge neighbours read boundary code 7.
- enable=0: ticks are ignored and counters hold; the catch check still runs.
- A tick in the same cycle as rst is ignored.

Decomposition:
- Package digger_pkg holds:
  - Tile codes: TILE_EMPTY=0, TILE_DIRT=3, TILE_EMERALD=4, TILE_BAG=5, TILE_BOUNDARY=7.
  - Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3.
  - Grid bounds: MAX_ROW=9, MAX_COL=14.
  - The goblin state enum.
- One combinational sub-module, goblin_dir_sel:
  - Inputs: dx, dy, cur dir, four tile codes.
  - Outputs: chosen dir and a move_valid flag.
  - Unit-testable on its own.

Test Plan:
- Spawn delay: rst, enable=1, tick every 4 clocks, SPAWN_DELAY=8 -> gobx/goby stay 0/14 and active=0 through the 8th tick; active=1 after it.
- Chase in tunnel: gob (0,14), digger (0,10), row 0 cols 10..14 = 0, MOVE_DIV=1 -> goby goes 13,12,11,10 on consecutive ticks, dir=LEFT; caught=1 one clock after goby==10.
- Blocked primary: gob (5,1), digger (9,1), down=3, left=0, up=0 -> moves LEFT to (5,0); not UP (priority order), no reverse.
- Dead end: gob (7,4) dir=RIGHT, only left=0, others 3/7 -> reverses to (7,3), dir=LEFT. All four blocked -> position and dir held.
- Boundary: gob (9,14), down=7, right=7 forced, digger (9,20 invalid)/(12,14) -> gobx never exceeds 9, goby never exceeds 14.
- Catch vs move and reset: catch and move slot in the same cycle -> no step, caught=1; assert rst while in CAUGHT -> next clock gobx=START_X, caught=0, state WAIT.

Source files
------------

// File: rtl/digger_pkg.sv
// rtl/digger_pkg.sv - shared tile codes, directions, grid bounds and goblin states
package digger_pkg;

  localparam logic [2:0] TILE_EMPTY    = 3'd0;
  localparam logic [2:0] TILE_DIRT     = 3'd3;
  localparam logic [2:0] TILE_EMERALD  = 3'd4;
  localparam logic [2:0] TILE_BAG      = 3'd5;
  localparam logic [2:0] TILE_BOUNDARY = 3'd7;

  localparam logic [3:0] MAX_ROW = 4'd9;
  localparam logic [3:0] MAX_COL = 4'd14;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ROAM   = 2'd1,
    ST_CAUGHT = 2'd2
  } gob_state_t;

  // Opposite direction is the same axis with the low bit flipped.
  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/goblin_dir_sel.sv
// rtl/goblin_dir_sel.sv - picks the goblin's next step from the digger delta and neighbour tiles
module goblin_dir_sel
  import digger_pkg::*;
(
  input  logic signed [4:0] dx,
  input  logic signed [4:0] dy,
  input  dir_t              cur_dir,
  input  logic [2:0]        up,
  input  logic [2:0]        down,
  input  logic [2:0]        left,
  input  logic [2:0]        right,
  output dir_t              dir_out,
  output logic              move_valid
);

  logic [3:0] open_v;
  logic [4:0] adx;
  logic [4:0] ady;
  logic       row_primary;
  dir_t       row_dir;
  dir_t       col_dir;
  dir_t       rev;
  dir_t       cand [7];
  logic [6:0] cval;
  logic       found;

  always_comb begin
    open_v[DIR_UP]    = (up    == TILE_EMPTY);
    open_v[DIR_DOWN]  = (down  == TILE_EMPTY);
    open_v[DIR_LEFT]  = (left  == TILE_EMPTY);
    open_v[DIR_RIGHT] = (right == TILE_EMPTY);
  end

  always_comb begin
    adx         = dx[4] ? -dx : dx;
    ady         = dy[4] ? -dy : dy;
    row_primary = (adx >= ady);
    row_dir     = dx[4] ? DIR_UP   : DIR_DOWN;
    col_dir     = dy[4] ? DIR_LEFT : DIR_RIGHT;
    rev         = dir_reverse(cur_dir);

    // Candidate list in priority order; toward-digger entries drop out on a zero delta.
    cand[0] = row_primary ? row_dir : col_dir;
    cval[0] = row_primary ? (dx != 5'sd0) : (dy != 5'sd0);
    cand[1] = row_primary ? col_dir : row_dir;
    cval[1] = row_primary ? (dy != 5'sd0) : (dx != 5'sd0);
    cand[2] = cur_dir;
    cand[3] = DIR_UP;
    cand[4] = DIR_LEFT;
    cand[5] = DIR_DOWN;
    cand[6] = DIR_RIGHT;
    cval[6:2] = 5'b11111;

    found   = 1'b0;
    dir_out = cur_dir;
    for (int i = 0; i < 7; i++) begin
      if (!found && cval[i] && (cand[i] != rev) && open_v[cand[i]]) begin
        found   = 1'b1;
        dir_out = cand[i];
      end
    end
    if (!found && open_v[rev]) begin
      found   = 1'b1;
      dir_out = rev;
    end
    move_valid = found;
  end

endmodule

// File: rtl/goblin_ctrl.sv
// rtl/goblin_ctrl.sv - goblin spawn/roam/catch state machine and position registers
module goblin_ctrl
  import digger_pkg::*;
#(
  parameter int START_X     = 0,
  parameter int START_Y     = 14,
  parameter int SPAWN_DELAY = 8,
  parameter int MOVE_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic [3:0] digx,
  input  logic [3:0] digy,
  input  logic [2:0] up,
  input  logic [2:0] down,
  input  logic [2:0] left,
  input  logic [2:0] right,
  output logic [3:0] gobx,
  output logic [3:0] goby,
  output logic [1:0] dir,
  output logic       active,
  output logic       caught
);

  localparam logic [3:0] START_X_L  = 4'(START_X);
  localparam logic [3:0] START_Y_L  = 4'(START_Y);
  localparam logic [7:0] SPAWN_LAST = 8'(SPAWN_DELAY - 1);
  localparam logic [3:0] MOVE_LAST  = 4'(MOVE_DIV - 1);

  gob_state_t state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic [3:0] mcnt, mcnt_nxt;
  logic [3:0] gobx_nxt, goby_nxt;
  dir_t       dir_q, dir_nxt;

  logic signed [4:0] dx;
  logic signed [4:0] dy;
  dir_t              sel_dir;
  logic              move_valid;
  logic              step_tick;
  logic              hit;

  assign dx        = $signed({1'b0, digx}) - $signed({1'b0, gobx});
  assign dy        = $signed({1'b0, digy}) - $signed({1'b0, goby});
  assign step_tick = enable & tick;
  assign hit       = (gobx == digx) && (goby == digy);

  goblin_dir_sel u_dir_sel (
    .dx         (dx),
    .dy         (dy),
    .cur_dir    (dir_q),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .dir_out    (sel_dir),
    .move_valid (move_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT;
      wcnt  <= '0;
      mcnt  <= '0;
      gobx  <= START_X_L;
      goby  <= START_Y_L;
      dir_q <= DIR_LEFT;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      mcnt  <= mcnt_nxt;
      gobx  <= gobx_nxt;
      goby  <= goby_nxt;
      dir_q <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    mcnt_nxt  = mcnt;
    gobx_nxt  = gobx;
    goby_nxt  = goby;
    dir_nxt   = dir_q;
    case (state)
      ST_WAIT: begin
        if (step_tick) begin
          if (wcnt == SPAWN_LAST) begin
            state_nxt = ST_ROAM;
            wcnt_nxt  = '0;
            mcnt_nxt  = '0;
          end else begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end
      end
      ST_ROAM: begin
        // A collision wins over any move slot landing in the same cycle.
        if (hit) begin
          state_nxt = ST_CAUGHT;
        end else if (step_tick) begin
          if (mcnt == MOVE_LAST) begin
            mcnt_nxt = '0;
            if (move_valid) begin
              dir_nxt = sel_dir;
              case (sel_dir)
                DIR_UP:    gobx_nxt = gobx - 4'd1;
                DIR_DOWN:  gobx_nxt = gobx + 4'd1;
                DIR_LEFT:  goby_nxt = goby - 4'd1;
                DIR_RIGHT: goby_nxt = goby + 4'd1;
                default:   gobx_nxt = gobx;
              endcase
            end
          end else begin
            mcnt_nxt = mcnt + 4'd1;
          end
        end
      end
      ST_CAUGHT: begin
        state_nxt = ST_CAUGHT;
      end
      default: begin
        state_nxt = ST_WAIT;
      end
    endcase
  end

  assign dir    = dir_q;
  assign active = (state == ST_ROAM);
  assign caught = (state == ST_CAUGHT);

endmodule

// File: tb/tb_goblin_ctrl.sv
// tb/tb_goblin_ctrl.sv - randomized goblin chase against a queue-based reference model
module tb_goblin_ctrl;

  localparam int SX    = 0;
  localparam int SY    = 14;
  localparam int SPAWN = 8;
  localparam int MDIV  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] digx = 4'd5;
  logic [3:0] digy = 4'd5;
  logic [2:0] up = 3'd7;
  logic [2:0] down = 3'd7;
  logic [2:0] left = 3'd7;
  logic [2:0] right = 3'd7;
  logic [3:0] gobx;
  logic [3:0] goby;
  logic [1:0] dir;
  logic       active;
  logic       caught;

  goblin_ctrl #(
    .START_X     (SX),
    .START_Y     (SY),
    .SPAWN_DELAY (SPAWN),
    .MOVE_DIV    (MDIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .enable (enable),
    .digx   (digx),
    .digy   (digy),
    .up     (up),
    .down   (down),
    .left   (left),
    .right  (right),
    .gobx   (gobx),
    .goby   (goby),
    .dir    (dir),
    .active (active),
    .caught (caught)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int map [10][15];

  // Model: phase 0 = waiting to spawn, 1 = roaming, 2 = caught.
  int m_phase, m_ticks, m_sub, m_x, m_y, m_dir;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int tile_at(input int x, input int y);
    if (x < 0 || x > 9 || y < 0 || y > 14) return 7;
    return map[x][y];
  endfunction

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int tile_dir(input int x, input int y, input int d);
    case (d)
      0: return tile_at(x - 1, y);
      1: return tile_at(x + 1, y);
      2: return tile_at(x, y - 1);
      default: return tile_at(x, y + 1);
    endcase
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_move(input int dgx, input int dgy);
    int dx, dy, rev, chosen;
    int q[$];
    dx = dgx - m_x;
    dy = dgy - m_y;
    if (iabs(dx) >= iabs(dy)) begin
      if (dx != 0) q.push_back(dx > 0 ? 1 : 0);
      if (dy != 0) q.push_back(dy > 0 ? 3 : 2);
    end else begin
      if (dy != 0) q.push_back(dy > 0 ? 3 : 2);
      if (dx != 0) q.push_back(dx > 0 ? 1 : 0);
    end
    q.push_back(m_dir);
    q.push_back(0);
    q.push_back(2);
    q.push_back(1);
    q.push_back(3);
    rev = opp(m_dir);
    chosen = -1;
    foreach (q[i])
      if (chosen < 0 && q[i] != rev && tile_dir(m_x, m_y, q[i]) == 0) chosen = q[i];
    if (chosen < 0 && tile_dir(m_x, m_y, rev) == 0) chosen = rev;
    if (chosen >= 0) begin
      m_dir = chosen;
      case (chosen)
        0: m_x = m_x - 1;
        1: m_x = m_x + 1;
        2: m_y = m_y - 1;
        default: m_y = m_y + 1;
      endcase
    end
  endtask

  task automatic model_clock(input bit r, input bit t, input bit e, input int dgx, input int dgy);
    if (r) begin
      m_phase = 0; m_ticks = 0; m_sub = 0; m_x = SX; m_y = SY; m_dir = 2;
      return;
    end
    if (m_phase == 0) begin
      if (t && e) begin
        m_ticks++;
        if (m_ticks == SPAWN) begin
          m_phase = 1;
          m_sub = 0;
        end
      end
    end else if (m_phase == 1) begin
      if (m_x == dgx && m_y == dgy) begin
        m_phase = 2;
      end else if (t && e) begin
        m_sub++;
        if (m_sub == MDIV) begin
          m_sub = 0;
          model_move(dgx, dgy);
        end
      end
    end
  endtask

  task automatic build_map(input int kind);
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 15; y++)
        case (kind)
          0: map[x][y] = ($urandom_range(0, 99) < 65) ? 0 : (($urandom_range(0, 2) == 0) ? 4 : 3);
          1: map[x][y] = 0;
          2: map[x][y] = ($urandom_range(0, 1) == 0) ? 3 : 5;
          default: map[x][y] = (x == 0 || y == 14 || x == 9) ? 0 : 3;
        endcase
  endtask

  task automatic drive_neighbours;
    up    = 3'(tile_dir(int'(gobx), int'(goby), 0));
    down  = 3'(tile_dir(int'(gobx), int'(goby), 1));
    left  = 3'(tile_dir(int'(gobx), int'(goby), 2));
    right = 3'(tile_dir(int'(gobx), int'(goby), 3));
  endtask

  task automatic run_cycle(input bit r);
    @(negedge clk);
    rst    = r;
    tick   = ($urandom_range(0, 2) == 0);
    enable = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 59) == 0) begin
      digx = 4'($urandom_range(0, 15));
      digy = 4'($urandom_range(0, 15));
    end
    drive_neighbours();
    model_clock(r, tick, enable, int'(digx), int'(digy));
    @(posedge clk);
    #1;
    check("gobx", int'(gobx), m_x);
    check("goby", int'(goby), m_y);
    check("dir", int'(dir), m_dir);
    check("active", int'(active), (m_phase == 1) ? 1 : 0);
    check("caught", int'(caught), (m_phase == 2) ? 1 : 0);
  endtask

  initial begin
    int after_catch;
    build_map(1);
    model_clock(1'b1, 1'b0, 1'b0, 0, 0);
    for (int ep = 0; ep < 48; ep++) begin
      build_map(ep % 4);
      digx = 4'($urandom_range(0, 15));
      digy = 4'($urandom_range(0, 15));
      run_cycle(1'b1);
      after_catch = 0;
      for (int c = 0; c < 350 && after_catch < 6; c++) begin
        run_cycle($urandom_range(0, 399) == 0);
        if (m_phase == 2) after_catch++;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
